// File: rtl/core_pkg.sv
// Shared encodings for the pipeline stall/flush controller.
package core_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_DWAIT = 2'b01,
        ST_IWAIT = 2'b10
    } state_e;

endpackage

// File: rtl/perf_counter.sv
// W-bit wrapping event counter with synchronous reset and increment enable.
module perf_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (inc) count_d = count_q + W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) count_q <= '0;
        else       count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Merges hazard-unit stall/flush requests and memory handshakes into per-stage
// register enables/clears; tracks memory waits and keeps performance counters.
module pipeline_stall_ctrl
    import core_pkg::*;
#(
    parameter int W        = 32,
    parameter int MAX_WAIT = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         StallF,
    input  logic         StallD,
    input  logic         FlushE,
    input  logic         PCSrcD,
    input  logic         IMemReady,
    input  logic         DMemReq_M,
    input  logic         DMemReady,
    output logic         EnPC,
    output logic         EnIF_ID,
    output logic         EnID_EX,
    output logic         EnEX_MEM,
    output logic         EnMEM_WB,
    output logic         ClrIF_ID,
    output logic         ClrID_EX,
    output logic         ClrMEM_WB,
    output logic         MemTimeout,
    output logic [W-1:0] CycleCount,
    output logic [W-1:0] StallCount,
    output logic [W-1:0] FlushCount
);

    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WAIT);

    state_e        state_q, state_d;
    logic [CW-1:0] wait_cnt_q, wait_cnt_d;
    logic          timeout_q, timeout_d;
    logic          dwait, load_use, iwait;

    assign dwait    = DMemReq_M & ~DMemReady;
    assign load_use = StallF | StallD | FlushE;
    assign iwait    = ~IMemReady;

    always_comb begin
        EnPC      = 1'b1;
        EnIF_ID   = 1'b1;
        EnID_EX   = 1'b1;
        EnEX_MEM  = 1'b1;
        EnMEM_WB  = 1'b1;
        ClrIF_ID  = 1'b0;
        ClrID_EX  = 1'b0;
        ClrMEM_WB = 1'b0;
        state_d   = ST_RUN;
        if (reset) begin
            // Flush bubbles into every stage while reset is held.
            EnPC      = 1'b0;
            EnIF_ID   = 1'b0;
            EnID_EX   = 1'b0;
            EnEX_MEM  = 1'b0;
            EnMEM_WB  = 1'b0;
            ClrIF_ID  = 1'b1;
            ClrID_EX  = 1'b1;
            ClrMEM_WB = 1'b1;
        end else if (dwait) begin
            EnPC      = 1'b0;
            EnIF_ID   = 1'b0;
            EnID_EX   = 1'b0;
            EnEX_MEM  = 1'b0;
            ClrMEM_WB = 1'b1;
            state_d   = ST_DWAIT;
        end else if (load_use) begin
            EnPC     = 1'b0;
            EnIF_ID  = 1'b0;
            ClrID_EX = 1'b1;
        end else if (PCSrcD) begin
            ClrIF_ID = 1'b1;
        end else if (iwait) begin
            EnPC     = 1'b0;
            ClrIF_ID = 1'b1;
            state_d  = ST_IWAIT;
        end
    end

    // The current wait cycle is counted, so wait_cnt equals the length of the
    // ongoing wait after each edge and the timeout lands on the MAX_WAIT-th cycle.
    always_comb begin
        wait_cnt_d = '0;
        if (state_d != ST_RUN) begin
            if (state_d != state_q)      wait_cnt_d = CW'(1);
            else if (wait_cnt_q < MAX_CNT) wait_cnt_d = wait_cnt_q + CW'(1);
            else                          wait_cnt_d = wait_cnt_q;
        end
        timeout_d = timeout_q | (wait_cnt_d == MAX_CNT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign MemTimeout = timeout_q;

    perf_counter #(.W(W)) u_cycle_cnt (
        .clk(clk), .reset(reset), .inc(1'b1), .count(CycleCount)
    );

    perf_counter #(.W(W)) u_stall_cnt (
        .clk(clk), .reset(reset), .inc(~EnPC), .count(StallCount)
    );

    perf_counter #(.W(W)) u_flush_cnt (
        .clk(clk), .reset(reset), .inc(ClrIF_ID | ClrID_EX), .count(FlushCount)
    );

endmodule
